// File: rtl/ifetch_queue.sv
// Prefetching instruction fetch front end: sequential PC generation, credit-limited
// memory requests, and an in-order instruction queue with redirect flush.
module ifetch_queue #(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       instruction,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SUM_W = CNT_W + 1;

  logic [ADDR_W-1:0] r_fetch_pc, r_rsp_pc;
  logic [PTR_W-1:0]  r_head, r_tail;
  logic [CNT_W-1:0]  r_count, r_out, r_drop;
  logic [31:0]       r_data [DEPTH];
  logic [ADDR_W-1:0] r_pc   [DEPTH];

  logic              w_credit, w_accept, w_pop, w_keep;
  logic [SUM_W-1:0]  w_sum;
  logic [ADDR_W-1:0] w_redir_pc;
  logic [CNT_W-1:0]  w_out_left;

  // Queued entries plus in-flight requests never exceed DEPTH, so a response always has a slot.
  assign w_sum      = SUM_W'(r_count) + SUM_W'(r_out);
  assign w_credit   = w_sum < SUM_W'(DEPTH);
  assign w_redir_pc = redirect_pc & ~ADDR_W'(3);
  assign w_out_left = r_out - CNT_W'(imem_rsp_valid);

  assign imem_req_valid = !reset && !redirect && w_credit;
  assign imem_req_addr  = r_fetch_pc;
  assign w_accept       = imem_req_valid && imem_req_ready;

  assign inst_valid  = !reset && (r_count != '0);
  assign instruction = inst_valid ? r_data[r_head] : '0;
  assign inst_pc     = inst_valid ? r_pc[r_head] : '0;
  assign w_pop       = inst_valid && inst_ready;
  assign w_keep      = imem_rsp_valid && (r_drop == '0) && !redirect;

  always_ff @(posedge clk) begin
    if (!reset && w_keep) begin
      r_data[r_tail] <= imem_rsp_data;
      r_pc[r_tail]   <= r_rsp_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_rsp_pc   <= RESET_PC;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_out      <= '0;
      r_drop     <= '0;
    end else if (redirect) begin
      // Everything still owed by memory, minus this cycle's response, is now stale.
      r_fetch_pc <= w_redir_pc;
      r_rsp_pc   <= w_redir_pc;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_out      <= w_out_left;
      r_drop     <= w_out_left;
    end else begin
      if (w_accept) r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
      r_out <= r_out + CNT_W'(w_accept) - CNT_W'(imem_rsp_valid);
      if (imem_rsp_valid && (r_drop != '0)) r_drop <= r_drop - CNT_W'(1);
      if (w_keep) begin
        r_tail   <= r_tail + PTR_W'(1);
        r_rsp_pc <= r_rsp_pc + ADDR_W'(4);
      end
      if (w_pop) r_head <= r_head + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_keep) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_keep) assert (r_count < CNT_W'(DEPTH));
  end
endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: latency-configurable memory model, queue-level
// reference model checked every cycle, and literal checks on fetch/consume order.
module tb_ifetch_queue;
  localparam int DEPTH = 4;

  logic        clk = 0;
  logic        reset = 1;
  logic        imem_req_valid, imem_req_ready = 0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 0;
  logic [31:0] imem_rsp_data = 0;
  logic        inst_valid, inst_ready = 0;
  logic [31:0] instruction, inst_pc;
  logic        redirect = 0;
  logic [31:0] redirect_pc = 0;

  ifetch_queue #(.DEPTH(DEPTH), .ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .instruction(instruction), .inst_pc(inst_pc),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] addr; bit drop; } inf_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;

  mreq_t       mq[$];
  inf_t        inf[$];
  ent_t        eq[$];
  logic [31:0] fpc = 0;
  logic [31:0] acc_log[$], pop_log[$];
  int          pop_cyc[$];
  int          cyc = 0, lat = 1;
  int          n_cmp = 0, n_bad = 0;

  function automatic logic [31:0] dat(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
    end
  endtask

  // Memory: answers in order, one word per cycle, lat cycles after acceptance.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1;
      imem_rsp_data  = dat(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      imem_rsp_valid = 0;
      imem_rsp_data  = 0;
    end
  end

  // Reference model: queue of (pc,data) entries plus list of owed responses.
  always @(negedge clk) begin
    bit          ev, eiv;
    logic [31:0] ei, ep;
    inf_t        r;
    ev  = !reset && !redirect && (eq.size() + inf.size() < DEPTH);
    eiv = !reset && (eq.size() > 0);
    ei  = eiv ? eq[0].data : 32'h0;
    ep  = eiv ? eq[0].pc : 32'h0;
    chk("req_valid", {31'b0, imem_req_valid}, {31'b0, ev});
    if (ev) chk("req_addr", imem_req_addr, fpc);
    chk("inst_valid", {31'b0, inst_valid}, {31'b0, eiv});
    chk("instruction", instruction, ei);
    chk("inst_pc", inst_pc, ep);

    if (imem_req_valid && imem_req_ready) acc_log.push_back(imem_req_addr);
    if (inst_valid && inst_ready) begin
      pop_log.push_back(inst_pc);
      pop_cyc.push_back(cyc);
    end
    if (reset) mq.delete();
    else if (imem_req_valid && imem_req_ready) mq.push_back('{imem_req_addr, cyc + lat});

    if (reset) begin
      eq.delete(); inf.delete(); fpc = 32'h0;
    end else if (redirect) begin
      if (imem_rsp_valid && inf.size() > 0) void'(inf.pop_front());
      foreach (inf[i]) inf[i].drop = 1;
      eq.delete();
      fpc = {redirect_pc[31:2], 2'b00};
    end else begin
      if (eiv && inst_ready) void'(eq.pop_front());
      if (imem_rsp_valid && inf.size() > 0) begin
        r = inf.pop_front();
        if (!r.drop) eq.push_back('{r.addr, dat(r.addr)});
      end
      if (ev && imem_req_ready) begin
        inf.push_back('{fpc, 1'b0});
        fpc = fpc + 32'd4;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input int l, input logic rdy, input logic irdy);
    reset = 1; redirect = 0; lat = l;
    imem_req_ready = rdy; inst_ready = irdy;
    step(2);
    reset = 0;
    acc_log.delete(); pop_log.delete(); pop_cyc.delete();
  endtask

  initial begin
    int t0;
    step(1);
    // 1: streaming at latency 1
    do_reset(1, 1, 1);
    t0 = cyc;
    step(10);
    chk("t1_acc0", at(acc_log, 0), 32'h0);
    chk("t1_acc1", at(acc_log, 1), 32'h4);
    chk("t1_acc3", at(acc_log, 3), 32'hC);
    chk("t1_first_lat", (pop_cyc.size() > 0) ? pop_cyc[0] - t0 : -1, 32'd2);
    chk("t1_pop0", at(pop_log, 0), 32'h0);

    // 2: decode stalled -> exactly DEPTH requests
    do_reset(1, 1, 0);
    step(8);
    chk("t2_nacc", acc_log.size(), DEPTH);
    chk("t2_acc3", at(acc_log, 3), 32'hC);
    inst_ready = 1;
    step(8);
    chk("t2_pop0", at(pop_log, 0), 32'h0);
    chk("t2_pop1", at(pop_log, 1), 32'h4);
    chk("t2_pop2", at(pop_log, 2), 32'h8);
    chk("t2_pop3", at(pop_log, 3), 32'hC);
    chk("t2_acc4", at(acc_log, 4), 32'h10);

    // 3: redirect with two late responses in flight and one queued
    do_reset(3, 1, 0);
    step(3);
    imem_req_ready = 0;
    step(1);
    redirect = 1; redirect_pc = 32'h100; imem_req_ready = 1;
    step(1);
    redirect = 0; inst_ready = 1;
    step(12);
    chk("t3_pop0", at(pop_log, 0), 32'h100);
    chk("t3_pop1", at(pop_log, 1), 32'h104);

    // 4: redirect coincides with a response and a head pop
    do_reset(2, 1, 0);
    step(3);
    redirect = 1; redirect_pc = 32'h200; inst_ready = 1;
    step(1);
    redirect = 0;
    step(10);
    chk("t4_pop0", at(pop_log, 0), 32'h0);
    chk("t4_pop1", at(pop_log, 1), 32'h200);
    chk("t4_pop2", at(pop_log, 2), 32'h204);

    // 5: memory stalls request port for 5 cycles
    do_reset(1, 0, 1);
    step(5);
    imem_req_ready = 1;
    step(10);
    chk("t5_acc0", at(acc_log, 0), 32'h0);
    chk("t5_acc1", at(acc_log, 1), 32'h4);
    chk("t5_pop0", at(pop_log, 0), 32'h0);
    chk("t5_pop1", at(pop_log, 1), 32'h4);
    chk("t5_pop2", at(pop_log, 2), 32'h8);

    // 6: address wrap and misaligned redirect target
    redirect = 1; redirect_pc = 32'hFFFF_FFFC;
    step(1);
    redirect = 0;
    acc_log.delete();
    step(2);
    chk("t6_wrap0", at(acc_log, 0), 32'hFFFF_FFFC);
    chk("t6_wrap1", at(acc_log, 1), 32'h0);
    redirect = 1; redirect_pc = 32'h103;
    step(1);
    redirect = 0;
    acc_log.delete(); pop_log.delete();
    step(8);
    chk("t6_align", at(acc_log, 0), 32'h100);
    chk("t6_pop0", at(pop_log, 0), 32'h100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
